// File: rtl/instruction_fetch.sv
// instruction_fetch: byte-serial fetch front end for the 8-bit core.
// Presents the PC to a combinational program memory and reads one byte per cycle.
// Assembles 1- and 2-byte instructions and queues them for the decoder.
// The queue drains over a valid/ready handshake, and a branch redirect flushes all in-flight state.
// Optional feature macro: FETCH_HALT_DETECT_EN stops fetching after a pushed BRA that targets itself.
module instruction_fetch #(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic       instr_len,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_addr,
    output logic       halted
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic {S_OPCODE, S_OPERAND} state_t;

    state_t        r_state;
    logic [7:0]    r_pc;
    logic [7:0]    r_op_byte;
    logic [7:0]    r_op_pc;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;

    logic [7:0]    r_q_opcode  [QUEUE_DEPTH];
    logic [7:0]    r_q_operand [QUEUE_DEPTH];
    logic          r_q_len     [QUEUE_DEPTH];
    logic [7:0]    r_q_pc      [QUEUE_DEPTH];

    logic          w_pop;
    logic          w_slot;
    logic          w_fetch;
    logic          w_two;
    logic          w_push;
    logic          w_halted;
    logic [7:0]    w_push_opcode;
    logic [7:0]    w_push_operand;
    logic          w_push_len;
    logic [7:0]    w_push_pc;

    // Immediate-carrying opcodes: MOV_IMM, CMP_IMM, BRA, BHI/BEQ.
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:2] == 6'b100000) || (b[7:2] == 6'b100011) ||
               (b[7:3] == 5'b10101)  || (b[7:3] == 5'b10110);
    endfunction

    assign address_bus   = r_pc;
    assign instr_valid   = (r_count != '0);
    assign instr_opcode  = r_q_opcode[r_rd_ptr];
    assign instr_operand = r_q_operand[r_rd_ptr];
    assign instr_len     = r_q_len[r_rd_ptr];
    assign instr_pc      = r_q_pc[r_rd_ptr];
    assign halted        = w_halted;

    // A popping head frees a slot in the same cycle, so a full queue can still stream.
    assign w_pop   = instr_valid & instr_ready;
    assign w_slot  = (r_count < DEPTH_C) | w_pop;
    assign w_fetch = w_slot & ~w_halted;
    assign w_two   = is_two_byte(data_bus);

    // Entry being completed this cycle: either a lone opcode or the latched opcode plus this operand.
    always_comb begin
        w_push_opcode  = data_bus;
        w_push_operand = 8'h00;
        w_push_len     = 1'b0;
        w_push_pc      = r_pc;
        w_push         = 1'b0;
        if (r_state == S_OPERAND) begin
            w_push_opcode  = r_op_byte;
            w_push_operand = data_bus;
            w_push_len     = 1'b1;
            w_push_pc      = r_op_pc;
            w_push         = w_fetch & ~redirect;
        end else begin
            w_push         = w_fetch & ~redirect & ~w_two;
        end
    end

    // Fetch FSM, PC and instruction queue; redirect discards everything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_OPCODE;
            r_pc      <= 8'h00;
            r_op_byte <= 8'h00;
            r_op_pc   <= 8'h00;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_opcode[i]  <= 8'h00;
                r_q_operand[i] <= 8'h00;
                r_q_len[i]     <= 1'b0;
                r_q_pc[i]      <= 8'h00;
            end
        end else if (redirect) begin
            r_state  <= S_OPCODE;
            r_pc     <= redirect_addr;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push) begin
                r_q_opcode[r_wr_ptr]  <= w_push_opcode;
                r_q_operand[r_wr_ptr] <= w_push_operand;
                r_q_len[r_wr_ptr]     <= w_push_len;
                r_q_pc[r_wr_ptr]      <= w_push_pc;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            if (w_fetch) begin
                r_pc <= r_pc + 8'd1;
                if (r_state == S_OPCODE) begin
                    r_op_byte <= data_bus;
                    r_op_pc   <= r_pc;
                    if (w_two)
                        r_state <= S_OPERAND;
                end else begin
                    r_state <= S_OPCODE;
                end
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    logic r_halted;

    // Latch halt when a BRA whose target is its own address enters the queue.
    always_ff @(posedge clk) begin
        if (!reset)
            r_halted <= 1'b0;
        else if (redirect)
            r_halted <= 1'b0;
        else if (w_push && (w_push_opcode == 8'hA8) && (w_push_operand == w_push_pc))
            r_halted <= 1'b1;
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed program images.
// Expected instructions are queued by the stimulus; a forked monitor checks every accepted head.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       instr_len;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic       halted;

    logic [7:0] rom [256];

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
        logic       len;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   pop_cnt = 0;
    int   base    = 0;

    instruction_fetch #(.QUEUE_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .address_bus(address_bus), .data_bus(data_bus),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_operand(instr_operand), .instr_len(instr_len), .instr_pc(instr_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
    );

    always #5 clk = ~clk;

    assign data_bus = rom[address_bus];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [7:0] op, input logic [7:0] opnd,
                                input logic len, input logic [7:0] pc);
        exp_t e;
        e.opcode = op; e.operand = opnd; e.len = len; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq();
        reset = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'h00;
        cyc(); cyc();
        exp_q.delete();
        base = pop_cnt;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    // Hold ready high until exactly n heads (since reset) have been accepted.
    task automatic wait_pops(input int n);
        int cycles;
        cycles = 0;
        instr_ready = 1'b1;
        while ((pop_cnt - base) < n && cycles < 200) begin
            cyc();
            cycles++;
        end
        instr_ready = 1'b0;
        if ((pop_cnt - base) < n) begin
            total++; bad++;
            $display("FAIL pop_timeout actual=%0d required=%0d", pop_cnt - base, n);
        end
    endtask

    task automatic monitor();
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && instr_ready) begin
                pop_cnt++;
                a.opcode = instr_opcode; a.operand = instr_operand;
                a.len = instr_len; a.pc = instr_pc;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_instr actual=%h required=none", a);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", 32'(a), 32'(e));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        rom_clear();
        // Reset values
        rst_seq();
        chk("rst_addr",    32'(address_bus),   32'h00);
        chk("rst_valid",   32'(instr_valid),   32'h0);
        chk("rst_opcode",  32'(instr_opcode),  32'h00);
        chk("rst_operand", 32'(instr_operand), 32'h00);
        chk("rst_len",     32'(instr_len),     32'h0);
        chk("rst_pc",      32'(instr_pc),      32'h00);
        chk("rst_halted",  32'(halted),        32'h0);

        // 2-byte MOV_IMM followed by a 1-byte instruction
        rom_clear(); rom[0] = 8'h82; rom[1] = 8'h00; rom[2] = 8'h70;
        rst_seq();
        expect_instr(8'h82, 8'h00, 1'b1, 8'd0);
        expect_instr(8'h70, 8'h00, 1'b0, 8'd2);
        reset = 1'b1; instr_ready = 1'b1;
        cyc();
        chk("t1_valid_c1", 32'(instr_valid), 32'h0);
        cyc();
        chk("t1_valid_c2", 32'(instr_valid), 32'h1);
        chk("t1_op_c2",    32'(instr_opcode), 32'h82);
        chk("t1_pc_c2",    32'(instr_pc),     32'h00);
        wait_pops(2);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: queue fills at 2 and the PC holds
        rom_clear();
        rst_seq();
        reset = 1'b1;
        repeat (6) cyc();
        chk("t2_addr_hold", 32'(address_bus), 32'h02);
        chk("t2_valid",     32'(instr_valid), 32'h1);
        chk("t2_head_pc",   32'(instr_pc),    32'h00);
        for (int i = 0; i < 6; i++) expect_instr(8'h00, 8'h00, 1'b0, 8'(i));
        wait_pops(6);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // CMP_IMM at 255 takes its operand from address 0
        rom_clear(); rom[255] = 8'h8C; rom[0] = 8'h11;
        rst_seq();
        reset = 1'b1; redirect = 1'b1; redirect_addr = 8'hFF;
        cyc();
        redirect = 1'b0;
        chk("t3_addr_ff", 32'(address_bus), 32'hFF);
        chk("t3_valid0",  32'(instr_valid), 32'h0);
        cyc();
        chk("t3_addr_wrap", 32'(address_bus), 32'h00);
        expect_instr(8'h8C, 8'h11, 1'b1, 8'hFF);
        wait_pops(1);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Redirect while an operand is pending and an entry is queued
        rom_clear(); rom[1] = 8'h82; rom[2] = 8'h55; rom[8'h21] = 8'h70;
        rst_seq();
        reset = 1'b1;
        cyc(); cyc();
        chk("t4_addr_operand", 32'(address_bus), 32'h02);
        chk("t4_valid_before", 32'(instr_valid), 32'h1);
        redirect = 1'b1; redirect_addr = 8'h21;
        cyc();
        redirect = 1'b0;
        chk("t4_addr_redir", 32'(address_bus), 32'h21);
        chk("t4_valid_flush", 32'(instr_valid), 32'h0);
        expect_instr(8'h70, 8'h00, 1'b0, 8'h21);
        expect_instr(8'h00, 8'h00, 1'b0, 8'h22);
        wait_pops(2);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Redirect in the same cycle the head is accepted
        rom_clear(); rom[8'h40] = 8'h70;
        rst_seq();
        reset = 1'b1;
        cyc(); cyc();
        expect_instr(8'h00, 8'h00, 1'b0, 8'h00);
        expect_instr(8'h70, 8'h00, 1'b0, 8'h40);
        expect_instr(8'h00, 8'h00, 1'b0, 8'h41);
        instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 8'h40;
        cyc();
        redirect = 1'b0;
        chk("t5_valid_flush", 32'(instr_valid), 32'h0);
        chk("t5_addr_redir",  32'(address_bus), 32'h40);
        wait_pops(3);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // Self-branch BRA 50 at address 50
        rom_clear(); rom[50] = 8'hA8; rom[51] = 8'd50;
        rst_seq();
        reset = 1'b1; redirect = 1'b1; redirect_addr = 8'd50;
        cyc();
        redirect = 1'b0;
        repeat (5) cyc();
`ifdef FETCH_HALT_DETECT_EN
        chk("t6_halted",    32'(halted),      32'h1);
        chk("t6_addr_frz",  32'(address_bus), 32'd52);
`else
        chk("t6_halted",    32'(halted),      32'h0);
        chk("t6_addr_run",  32'(address_bus), 32'd53);
`endif
        expect_instr(8'hA8, 8'd50, 1'b1, 8'd50);
        wait_pops(1);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        redirect = 1'b1; redirect_addr = 8'h00;
        cyc();
        redirect = 1'b0;
        chk("t6_halt_clr",  32'(halted),      32'h0);
        chk("t6_addr_zero", 32'(address_bus), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
